// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: an instruction-fetch port and a load/store port
// share one memory request channel with exactly one transaction in flight.
// Data normally wins when both ports request; a starvation counter lets the
// fetch port through after STARVE_LIMIT consecutive contended data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  starve_reg;
    logic        owner_data_reg;   // 0 = inst owns the transaction, 1 = data
    logic        wr_reg;
    logic [3:0]  wstrb_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        grant_inst;
    logic        grant_data;

    // Read data goes straight to both ports; the owner's data_ok qualifies it.
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // The memory request fields come from the latched copy so they stay
    // stable for the whole address phase regardless of what the ports do.
    assign mem_wr    = wr_reg;
    assign mem_wstrb = wstrb_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

    // State register; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Grant decision, next state and handshake strobes. Everything is gated
    // by resetn so no strobe can escape while reset is held.
    always_comb begin
        state_next   = state_reg;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        mem_req      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (resetn) begin
                    if (inst_req && (!data_req || starve_reg == LIMIT)) begin
                        grant_inst = 1'b1;
                    end else if (data_req) begin
                        grant_data = 1'b1;
                    end
                    if (grant_inst || grant_data) begin
                        state_next = REQ;
                    end
                end
                inst_addr_ok = grant_inst;
                data_addr_ok = grant_data;
            end
            REQ: begin
                mem_req = resetn;
                if (mem_addr_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (resetn && mem_data_ok) begin
                    inst_data_ok = !owner_data_reg;
                    data_data_ok = owner_data_reg;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the winning request and track how long inst has been starved.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_reg     <= 4'd0;
            owner_data_reg <= 1'b0;
            wr_reg         <= 1'b0;
            wstrb_reg      <= 4'd0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
        end else if (grant_inst) begin
            starve_reg     <= 4'd0;
            owner_data_reg <= 1'b0;
            wr_reg         <= 1'b0;
            wstrb_reg      <= 4'd0;
            addr_reg       <= inst_addr;
            wdata_reg      <= 32'd0;
        end else if (grant_data) begin
            if (inst_req && starve_reg != LIMIT) begin
                starve_reg <= starve_reg + 4'd1;
            end
            owner_data_reg <= 1'b1;
            wr_reg         <= data_wr;
            wstrb_reg      <= data_wstrb;
            addr_reg       <= data_addr;
            wdata_reg      <= data_wdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table covering reset,
// lone fetch, spurious responses, contention/starvation order and reset in
// WAIT, followed by a hand-written store sequence with an address stall.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    // Expected strobe vector {inst_addr_ok, data_addr_ok, mem_req, inst_data_ok, data_data_ok}
    localparam logic [4:0] NO = 5'b00000;
    localparam logic [4:0] IA = 5'b10000;
    localparam logic [4:0] DA = 5'b01000;
    localparam logic [4:0] MR = 5'b00100;
    localparam logic [4:0] ID = 5'b00010;
    localparam logic [4:0] DD = 5'b00001;

    localparam logic [31:0] IADDR = 32'h1C00_0000;
    localparam logic [31:0] DADDR = 32'h0000_0102;
    localparam logic [31:0] RDATA = 32'h0280_0C0C;

    typedef struct {
        logic        rstn;
        logic        ireq;
        logic        dreq;
        logic        maok;
        logic        mdok;
        logic [4:0]  exp;
        logic [31:0] eaddr;   // checked only when mem_req is expected
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    function automatic void add(input logic rstn, input logic ireq, input logic dreq,
                                input logic maok, input logic mdok,
                                input logic [4:0] exp, input logic [31:0] eaddr);
        vec_t v;
        v.rstn = rstn; v.ireq = ireq; v.dreq = dreq;
        v.maok = maok; v.mdok = mdok; v.exp = exp; v.eaddr = eaddr;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {inst_addr_ok, data_addr_ok, mem_req, inst_data_ok, data_data_ok};
    endfunction

    initial begin
        resetn      = 1'b0;
        inst_req    = 1'b0;
        inst_addr   = IADDR;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_wstrb  = 4'h0;
        data_addr   = DADDR;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = RDATA;

        // Reset, with requests asserted: nothing may be granted meanwhile.
        add(0, 1, 1, 0, 0, NO, 0);
        add(0, 1, 1, 0, 1, NO, 0);
        // Lone fetch: accept T, mem_req T+1, data_ok T+2.
        add(1, 1, 0, 0, 0, IA, 0);
        add(1, 0, 0, 1, 0, MR, IADDR);
        add(1, 0, 0, 0, 1, ID, 0);
        // Spurious mem_data_ok in IDLE.
        add(1, 0, 0, 0, 1, NO, 0);
        // Simultaneous request with starve_cnt=0: data first, inst waits.
        add(1, 1, 1, 0, 0, DA, 0);
        add(1, 1, 0, 0, 0, MR, DADDR);
        add(1, 1, 0, 0, 1, MR, DADDR);     // mem_data_ok in REQ ignored
        add(1, 1, 0, 1, 0, MR, DADDR);
        add(1, 1, 0, 1, 0, NO, 0);         // mem_addr_ok in WAIT ignored
        add(1, 1, 0, 0, 1, DD, 0);
        add(1, 1, 0, 0, 0, IA, 0);
        add(1, 0, 0, 1, 0, MR, IADDR);
        add(1, 0, 0, 0, 1, ID, 0);
        // Continuous contention: data x4, inst, data.
        for (int t = 0; t < 6; t++) begin
            if (t == 4) begin
                add(1, 1, 1, 0, 0, IA, 0);
                add(1, 1, 1, 1, 0, MR, IADDR);
                add(1, 1, 1, 0, 1, ID, 0);
            end else begin
                add(1, 1, 1, 0, 0, DA, 0);
                add(1, 1, 1, 1, 0, MR, DADDR);
                add(1, 1, 1, 0, 1, DD, 0);
            end
        end
        // Reset in WAIT, then a late mem_data_ok alongside a new fetch.
        add(1, 1, 0, 0, 0, IA, 0);
        add(1, 0, 0, 1, 0, MR, IADDR);
        add(0, 0, 0, 0, 0, NO, 0);
        add(1, 1, 0, 0, 1, IA, 0);
        add(1, 0, 0, 1, 0, MR, IADDR);
        add(1, 0, 0, 0, 1, ID, 0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            resetn      = vecs[i].rstn;
            inst_req    = vecs[i].ireq;
            data_req    = vecs[i].dreq;
            mem_addr_ok = vecs[i].maok;
            mem_data_ok = vecs[i].mdok;
            #1;
            $display("vec %0d in={%b%b%b%b%b} out=%b exp=%b", i, vecs[i].rstn, vecs[i].ireq,
                     vecs[i].dreq, vecs[i].maok, vecs[i].mdok, strobes(), vecs[i].exp);
            chk($sformatf("vec%0d_strobes", i), 32'(strobes()), 32'(vecs[i].exp));
            if (vecs[i].exp[2]) chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].eaddr);
            if (vecs[i].exp[1]) chk($sformatf("vec%0d_inst_rdata", i), inst_rdata, RDATA);
        end

        // Store with a 3-cycle address stall.
        @(negedge clk);
        resetn = 1'b1; inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h4; data_wdata = 32'h00AB_0000;
        #1;
        $display("store accept out=%b", strobes());
        chk("store_accept", 32'(strobes()), 32'(DA));
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_wdata = 32'h0;
            mem_addr_ok = (s == 3);
            #1;
            $display("store req cycle %0d out=%b wr=%b wstrb=%h addr=%h wdata=%h",
                     s, strobes(), mem_wr, mem_wstrb, mem_addr, mem_wdata);
            chk($sformatf("store_req%0d", s), 32'(strobes()), 32'(MR));
            chk($sformatf("store_wr%0d", s), 32'(mem_wr), 32'd1);
            chk($sformatf("store_wstrb%0d", s), 32'(mem_wstrb), 32'h4);
            chk($sformatf("store_addr%0d", s), mem_addr, DADDR);
            chk($sformatf("store_wdata%0d", s), mem_wdata, 32'h00AB_0000);
        end
        @(negedge clk);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        #1;
        chk("store_wait_idle", 32'(strobes()), 32'(NO));
        @(negedge clk);
        mem_data_ok = 1'b1;
        #1;
        $display("store complete out=%b", strobes());
        chk("store_done", 32'(strobes()), 32'(DD));
        @(negedge clk);
        mem_data_ok = 1'b0;
        #1;
        chk("store_pulse_end", 32'(strobes()), 32'(NO));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: number of consecutive data grants taken while inst_req is pending before inst wins (range 1..15).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port inst_req, input, 1: fetch request; held high until inst_addr_ok.
REQ-005 SHALL have port inst_addr, input, 32: fetch address.
REQ-006 SHALL have port inst_addr_ok, output, 1: fetch request accepted this cycle.
REQ-007 SHALL have port inst_data_ok, output, 1: fetch data valid this cycle.
REQ-008 SHALL have port inst_rdata, output, 32: fetch data.
REQ-009 SHALL have port data_req, input, 1: load/store request; held high until data_addr_ok.
REQ-010 SHALL have port data_wr, input, 1: 1 = store, 0 = load.
REQ-011 SHALL have port data_wstrb, input, 4: store byte enables.
REQ-012 SHALL have port data_addr, input, 32: load/store address.
REQ-013 SHALL have port data_wdata, input, 32: store data, already byte-lane aligned.
REQ-014 SHALL have port data_addr_ok, output, 1: load/store accepted this cycle.
REQ-015 SHALL have port data_data_ok, output, 1: load data valid, or store complete.
REQ-016 SHALL have port data_rdata, output, 32: load data.
REQ-017 SHALL have ports mem_req/mem_wr (output, 1), mem_wstrb (output, 4), mem_addr/mem_wdata (output, 32): shared memory request.
REQ-018 SHALL have ports mem_addr_ok/mem_data_ok (input, 1), mem_rdata (input, 32): shared memory response.

Function
REQ-019 SHALL keep exactly one transaction outstanding at a time; FSM states IDLE, REQ, WAIT.
REQ-020 IDLE: if either req is high, SHALL grant one requester, pulse its addr_ok for that cycle, latch owner/wr/wstrb/addr/wdata (wr=0, wstrb=0 for inst), and go to REQ; otherwise stay in IDLE.
REQ-021 Grant rule SHALL be: data wins when both request, unless starve_cnt == STARVE_LIMIT, in which case inst wins; a lone requester always wins.
REQ-022 starve_cnt (4-bit) SHALL increment, saturating at STARVE_LIMIT, on every data grant made while inst_req is high; it SHALL clear to 0 on any inst grant; it SHALL be unchanged otherwise.
REQ-023 REQ: SHALL drive mem_req=1 and the latched fields; on mem_addr_ok=1 go to WAIT; latched fields SHALL stay stable until then.
REQ-024 WAIT: mem_req=0; on mem_data_ok=1 SHALL pulse the owner's data_ok for that same cycle (combinational) and return to IDLE.
REQ-025 inst_rdata and data_rdata SHALL both pass mem_rdata combinationally; only the owner's data_ok qualifies it.
REQ-026 addr_ok SHALL be asserted only in IDLE; data_ok SHALL be asserted only in WAIT; never both inst and data strobes in one cycle.
REQ-027 mem_data_ok while in IDLE or REQ SHALL be ignored; mem_addr_ok outside REQ SHALL be ignored.
REQ-028 Latency: minimum accept-to-data_ok = 2 cycles (accept T, mem_req T+1 with mem_addr_ok, data_ok T+2); next accept earliest the cycle after data_ok.
REQ-029 Stores SHALL complete via data_data_ok exactly like loads; data_rdata value is don't-care on store completion.

Reset
REQ-030 resetn=0 at a clock edge SHALL force state IDLE, starve_cnt=0, latched fields 0, owner=inst.
REQ-031 During and after reset, until a new grant: mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok SHALL be 0.
REQ-032 Reset mid-transaction SHALL drop the transaction; a mem_data_ok arriving afterwards SHALL produce no data_ok.

Verification
REQ-033 Lone fetch: inst_req, addr 0x1C000000, memory acks addr next cycle and data the cycle after with 0x02800C0C -> inst_addr_ok at T, mem_req/mem_addr=0x1C000000 at T+1, inst_data_ok with inst_rdata 0x02800C0C at T+2.
REQ-034 Store: data_req, wr=1, wstrb=0x4, addr 0x00000102, wdata 0x00AB0000 -> mem_wr=1, mem_wstrb=0x4, mem_wdata=0x00AB0000 held through a 3-cycle mem_addr_ok stall; data_data_ok 1 cycle pulse on mem_data_ok; inst_data_ok stays 0.
REQ-035 Contention, STARVE_LIMIT=4: both reqs held continuously -> grant order data,data,data,data,inst,data,... (starve_cnt 1,2,3,4,0,1).
REQ-036 Simultaneous request in IDLE with starve_cnt=0 -> only data_addr_ok pulses; inst_req stays pending with inst_addr_ok=0 until the data transaction's data_ok.
REQ-037 Reset in WAIT, then mem_data_ok pulse 1 cycle after reset release -> no data_ok; state IDLE; next inst_req accepted in that cycle.
REQ-038 Spurious mem_data_ok in IDLE with no requests -> no data_ok, state unchanged, mem_req stays 0.
